// File: rtl/fcl_pkg.sv
// Shared constants and FSM state type for the first binarized FC layer.
// PRO_CH_CNT is the number of neuron groups the layer walks at the default
// sizes (N_OUT_DEF / PRO_PARALLEL).
package fcl_pkg;

    localparam int unsigned PRO_WIDTH    = 8;
    localparam int unsigned PRO_PARALLEL = 16;
    localparam int unsigned ACC_WIDTH    = 20;
    localparam int unsigned N_IN_DEF     = 784;
    localparam int unsigned N_OUT_DEF    = 2048;
    localparam int unsigned PRO_CH_CNT   = N_OUT_DEF / PRO_PARALLEL;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        DRAIN,
        OUT,
        DONE
    } fcl_state_t;

endpackage

// File: rtl/fcl_pro_ctrl.sv
// Sequencer for the fcl_pro binarized fully-connected datapath.
// Walks N_OUT neurons in groups of PRO_PARALLEL. For each group it streams
// N_IN pixels and weight words from the fixed-latency memories into the
// datapath. It then captures the group result and offers it downstream
// over a valid/ready handshake.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   start, cfg_shift   layer launch (IDLE only); result shift latched on start
//   busy, done         layer in progress; one-cycle completion pulse
//   in_rd_en/in_addr   input buffer read (data returns next cycle on in_rdata)
//   w_rd_en/w_addr     weight memory read (data returns next cycle on w_rdata)
//   dp_pixel, dp_w     beat presented to the datapath
//   dp_first           datapath loads rather than accumulates on this beat
//   dp_shift           result shift for the whole layer
//   dp_out             datapath result lanes
//   out_valid/ready    downstream handshake for out_data / out_group
module fcl_pro_ctrl #(
    parameter int unsigned N_IN         = fcl_pkg::N_IN_DEF,
    parameter int unsigned N_OUT        = fcl_pkg::N_OUT_DEF,
    parameter int unsigned PRO_PARALLEL = fcl_pkg::PRO_PARALLEL,
    parameter int unsigned PRO_WIDTH    = fcl_pkg::PRO_WIDTH,
    parameter int unsigned ACC_WIDTH    = fcl_pkg::ACC_WIDTH,
    localparam int unsigned GRP_CNT     = N_OUT / PRO_PARALLEL,
    localparam int unsigned PIX_W       = (N_IN > 1) ? $clog2(N_IN) : 1,
    localparam int unsigned GRP_W       = (GRP_CNT > 1) ? $clog2(GRP_CNT) : 1,
    localparam int unsigned WADDR_W     = (N_IN * GRP_CNT > 1) ? $clog2(N_IN * GRP_CNT) : 1,
    localparam int unsigned SHIFT_W     = $clog2(ACC_WIDTH),
    localparam int unsigned DATA_W      = PRO_PARALLEL * PRO_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [SHIFT_W-1:0]      cfg_shift,
    output logic                    busy,
    output logic                    done,
    output logic                    in_rd_en,
    output logic [PIX_W-1:0]        in_addr,
    input  logic [PRO_WIDTH-1:0]    in_rdata,
    output logic                    w_rd_en,
    output logic [WADDR_W-1:0]      w_addr,
    input  logic [PRO_PARALLEL-1:0] w_rdata,
    output logic [PRO_WIDTH-1:0]    dp_pixel,
    output logic [PRO_PARALLEL-1:0] dp_w,
    output logic                    dp_first,
    output logic [SHIFT_W-1:0]      dp_shift,
    input  logic [DATA_W-1:0]       dp_out,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W-1:0]       out_data,
    output logic [GRP_W-1:0]        out_group
);

    import fcl_pkg::*;

    fcl_state_t          state_q, state_d;
    logic [PIX_W-1:0]    pix_d;
    logic [GRP_W-1:0]    grp_q, grp_d;
    logic [WADDR_W-1:0]  w_addr_d;
    logic [SHIFT_W-1:0]  shift_d;
    logic                drain_q, drain_d;
    logic                rd_d;
    logic                done_d;
    logic                capture;
    logic                last_pix;
    logic                last_grp;

    logic                beat_valid_q;
    logic                beat_first_q;
    logic [PRO_WIDTH-1:0]    pix_hold_q;
    logic [PRO_PARALLEL-1:0] w_hold_q;

    assign last_pix = (in_addr == PIX_W'(N_IN - 1));
    assign last_grp = (grp_q == GRP_W'(GRP_CNT - 1));

    // Next-state, counter and strobe decode.
    // w_addr runs as a single counter across groups, so it always equals
    // grp*N_IN + pix without a multiplier.
    always_comb begin
        state_d  = state_q;
        pix_d    = in_addr;
        grp_d    = grp_q;
        w_addr_d = w_addr;
        shift_d  = dp_shift;
        drain_d  = 1'b0;
        rd_d     = 1'b0;
        done_d   = 1'b0;
        capture  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = RUN;
                    shift_d  = cfg_shift;
                    grp_d    = '0;
                    pix_d    = '0;
                    w_addr_d = '0;
                    rd_d     = 1'b1;
                end
            end
            RUN: begin
                if (last_pix) begin
                    state_d = DRAIN;
                    pix_d   = '0;
                end else begin
                    pix_d    = in_addr + PIX_W'(1);
                    w_addr_d = w_addr + WADDR_W'(1);
                    rd_d     = 1'b1;
                end
            end
            DRAIN: begin
                // First cycle: last beat reaches the datapath.
                // Second cycle: the completed sum is visible on dp_out.
                if (!drain_q) begin
                    drain_d = 1'b1;
                end else begin
                    capture = 1'b1;
                    state_d = OUT;
                end
            end
            OUT: begin
                if (out_ready) begin
                    if (last_grp) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d  = RUN;
                        grp_d    = grp_q + GRP_W'(1);
                        w_addr_d = w_addr + WADDR_W'(1);
                        rd_d     = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            in_addr   <= '0;
            grp_q     <= '0;
            w_addr    <= '0;
            dp_shift  <= '0;
            drain_q   <= 1'b0;
            in_rd_en  <= 1'b0;
            w_rd_en   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_addr   <= pix_d;
            grp_q     <= grp_d;
            w_addr    <= w_addr_d;
            dp_shift  <= shift_d;
            drain_q   <= drain_d;
            in_rd_en  <= rd_d;
            w_rd_en   <= rd_d;
            busy      <= (state_d != IDLE);
            done      <= done_d;
            out_valid <= (state_d == OUT);
        end
    end

    // Beat tracking (read strobe delayed by the memory latency) and result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_valid_q <= 1'b0;
            beat_first_q <= 1'b0;
            pix_hold_q   <= '0;
            w_hold_q     <= '0;
            out_data     <= '0;
            out_group    <= '0;
        end else begin
            beat_valid_q <= in_rd_en;
            beat_first_q <= in_rd_en && (in_addr == '0);
            if (beat_valid_q) begin
                pix_hold_q <= in_rdata;
                w_hold_q   <= w_rdata;
            end
            if (capture) begin
                out_data  <= dp_out;
                out_group <= grp_q;
            end
        end
    end

    // Memory data bypasses straight to the datapath on a beat so the last
    // beat lands in the first drain cycle; between beats the last value holds.
    assign dp_pixel = beat_valid_q ? in_rdata : pix_hold_q;
    assign dp_w     = beat_valid_q ? w_rdata  : w_hold_q;
    assign dp_first = beat_valid_q && beat_first_q;

endmodule

// File: tb/tb_fcl_pro_ctrl.sv
// Directed bench for fcl_pro_ctrl: instance A (N_IN=4, 2 groups of 2) and
// instance B (N_IN=1, 2 groups of 2), each with a memory and datapath model.
module tb_fcl_pro_ctrl;

    logic clk;
    logic rst;

    // Instance A signals
    logic        a_start;
    logic [4:0]  a_cfg_shift;
    logic        a_busy, a_done;
    logic        a_in_rd_en;
    logic [1:0]  a_in_addr;
    logic [7:0]  a_in_rdata;
    logic        a_w_rd_en;
    logic [2:0]  a_w_addr;
    logic [1:0]  a_w_rdata;
    logic [7:0]  a_dp_pixel;
    logic [1:0]  a_dp_w;
    logic        a_dp_first;
    logic [4:0]  a_dp_shift;
    logic [15:0] a_dp_out;
    logic        a_out_valid, a_out_ready;
    logic [15:0] a_out_data;
    logic        a_out_group;

    // Instance B signals
    logic        b_start;
    logic [4:0]  b_cfg_shift;
    logic        b_busy, b_done;
    logic        b_in_rd_en;
    logic        b_in_addr;
    logic [7:0]  b_in_rdata;
    logic        b_w_rd_en;
    logic        b_w_addr;
    logic [1:0]  b_w_rdata;
    logic [7:0]  b_dp_pixel;
    logic [1:0]  b_dp_w;
    logic        b_dp_first;
    logic [4:0]  b_dp_shift;
    logic [15:0] b_dp_out;
    logic        b_out_valid, b_out_ready;
    logic [15:0] b_out_data;
    logic        b_out_group;

    fcl_pro_ctrl #(.N_IN(4), .N_OUT(4), .PRO_PARALLEL(2), .PRO_WIDTH(8), .ACC_WIDTH(20)) u_a (
        .clk(clk), .rst(rst), .start(a_start), .cfg_shift(a_cfg_shift),
        .busy(a_busy), .done(a_done),
        .in_rd_en(a_in_rd_en), .in_addr(a_in_addr), .in_rdata(a_in_rdata),
        .w_rd_en(a_w_rd_en), .w_addr(a_w_addr), .w_rdata(a_w_rdata),
        .dp_pixel(a_dp_pixel), .dp_w(a_dp_w), .dp_first(a_dp_first),
        .dp_shift(a_dp_shift), .dp_out(a_dp_out),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_data(a_out_data), .out_group(a_out_group)
    );

    fcl_pro_ctrl #(.N_IN(1), .N_OUT(4), .PRO_PARALLEL(2), .PRO_WIDTH(8), .ACC_WIDTH(20)) u_b (
        .clk(clk), .rst(rst), .start(b_start), .cfg_shift(b_cfg_shift),
        .busy(b_busy), .done(b_done),
        .in_rd_en(b_in_rd_en), .in_addr(b_in_addr), .in_rdata(b_in_rdata),
        .w_rd_en(b_w_rd_en), .w_addr(b_w_addr), .w_rdata(b_w_rdata),
        .dp_pixel(b_dp_pixel), .dp_w(b_dp_w), .dp_first(b_dp_first),
        .dp_shift(b_dp_shift), .dp_out(b_dp_out),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_data(b_out_data), .out_group(b_out_group)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memories with one-cycle read latency
    logic [7:0] pmem_a [4];
    logic [1:0] wmem_a [8];
    logic [7:0] pmem_b [2];
    logic [1:0] wmem_b [2];

    always_ff @(posedge clk) begin
        if (a_in_rd_en) a_in_rdata <= pmem_a[a_in_addr];
        if (a_w_rd_en)  a_w_rdata  <= wmem_a[a_w_addr];
        if (b_in_rd_en) b_in_rdata <= pmem_b[b_in_addr];
        if (b_w_rd_en)  b_w_rdata  <= wmem_b[b_w_addr];
    end

    // Binarized datapath model: weight bit 1 adds the pixel, 0 subtracts it;
    // the accumulator updates every cycle, loading on dp_first.
    function automatic logic signed [19:0] bin_term(input logic [7:0] p, input logic b);
        logic signed [19:0] v;
        v = $signed({12'd0, p});
        return b ? v : -v;
    endfunction

    logic signed [19:0] acc_a [2];
    logic signed [19:0] acc_b [2];

    always_ff @(posedge clk) begin
        for (int l = 0; l < 2; l++) begin
            acc_a[l] <= a_dp_first ? bin_term(a_dp_pixel, a_dp_w[l])
                                   : acc_a[l] + bin_term(a_dp_pixel, a_dp_w[l]);
            acc_b[l] <= b_dp_first ? bin_term(b_dp_pixel, b_dp_w[l])
                                   : acc_b[l] + bin_term(b_dp_pixel, b_dp_w[l]);
        end
    end

    always_comb begin
        a_dp_out = '0;
        b_dp_out = '0;
        for (int l = 0; l < 2; l++) begin
            a_dp_out[l*8 +: 8] = 8'(acc_a[l] >>> a_dp_shift);
            b_dp_out[l*8 +: 8] = 8'(acc_b[l] >>> b_dp_shift);
        end
    end

    // Bookkeeping
    int pass_cnt;
    int total_cnt;
    int cyc;
    int rd_cnt;
    int rd_in [64];
    int rd_w  [64];
    int done_cnt;
    int first_cnt;
    int first_cyc0;
    int first_pix;
    int b_rd_cnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance one cycle and sample #1 after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (a_in_rd_en) begin
            if (rd_cnt < 64) begin
                rd_in[rd_cnt] = int'(a_in_addr);
                rd_w[rd_cnt]  = int'(a_w_addr);
            end
            rd_cnt++;
        end
        if (a_done) done_cnt++;
        if (a_dp_first) begin
            if (first_cnt == 0) first_cyc0 = cyc;
            first_cnt++;
            first_pix = int'(a_dp_pixel);
        end
        if (b_in_rd_en) b_rd_cnt++;
    endtask

    int n;
    int s;
    int r0, r1, d0;

    initial begin
        pass_cnt = 0; total_cnt = 0; cyc = 0; rd_cnt = 0; done_cnt = 0;
        first_cnt = 0; first_cyc0 = 0; first_pix = 0; b_rd_cnt = 0;

        pmem_a[0] = 8'd10; pmem_a[1] = 8'd20; pmem_a[2] = 8'd30; pmem_a[3] = 8'd40;
        wmem_a[0] = 2'b11; wmem_a[1] = 2'b11; wmem_a[2] = 2'b11; wmem_a[3] = 2'b11;
        wmem_a[4] = 2'b01; wmem_a[5] = 2'b11; wmem_a[6] = 2'b01; wmem_a[7] = 2'b11;
        pmem_b[0] = 8'd7;  pmem_b[1] = 8'd0;
        wmem_b[0] = 2'b11; wmem_b[1] = 2'b10;

        rst = 1'b1;
        a_start = 1'b0; a_cfg_shift = 5'd0; a_out_ready = 1'b1;
        b_start = 1'b0; b_cfg_shift = 5'd0; b_out_ready = 1'b1;
        repeat (3) tick();

        // Reset state
        chk("rst_ctl",  {a_busy, a_done, a_in_rd_en, a_w_rd_en, a_dp_first, a_out_valid}, 64'd0);
        chk("rst_addr", {a_in_addr, a_w_addr}, 64'd0);
        chk("rst_dp",   {a_dp_pixel, a_dp_w, a_dp_shift}, 64'd0);
        chk("rst_out",  {a_out_data, a_out_group}, 64'd0);
        chk("rst_b_ctl", {b_busy, b_done, b_in_rd_en, b_out_valid}, 64'd0);
        rst = 1'b0;
        tick();

        // Full layer, out_ready high, shift 0
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        s = cyc;
        n = 1;
        chk("busy_after_start", a_busy, 1);
        while (!a_out_valid && n < 100) begin tick(); n++; end
        chk("lat_first_valid", n, 7);
        chk("g0_group", a_out_group, 0);
        chk("g0_data", a_out_data, 16'h6464);
        chk("first_beat_cycle", first_cyc0, s + 1);
        n = 0;
        do begin tick(); n++; end while (!a_out_valid && n < 100);
        chk("lat_group", n, 7);
        chk("g1_group", a_out_group, 1);
        chk("g1_data", a_out_data, 16'h1464);
        d0 = done_cnt;
        tick();
        chk("done_pulse", {a_done, a_busy}, 2'b11);
        tick();
        chk("done_clear", {a_done, a_busy}, 2'b00);
        chk("done_once", done_cnt - d0, 1);
        chk("read_count", rd_cnt, 8);
        for (int i = 0; i < 8; i++) begin
            chk("rd_in_addr", rd_in[i], i % 4);
            chk("rd_w_addr", rd_w[i], i);
        end
        chk("first_cnt", first_cnt, 2);
        chk("first_pix", first_pix, 10);

        // Back-pressure in OUT
        a_out_ready = 1'b0;
        r0 = rd_cnt;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        n = 1;
        while (!a_out_valid && n < 100) begin tick(); n++; end
        chk("bp_lat", n, 7);
        r1 = rd_cnt;
        chk("bp_reads_g0", r1 - r0, 4);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_valid_held", a_out_valid, 1);
            chk("bp_hold", {a_out_data, a_out_group}, {16'h6464, 1'b0});
        end
        chk("bp_no_reads", rd_cnt - r1, 0);
        a_out_ready = 1'b1;
        tick();
        chk("bp_resume", {a_in_rd_en, a_in_addr, a_w_addr}, {1'b1, 2'd0, 3'd4});
        n = 0;
        while (!a_done && n < 100) begin tick(); n++; end
        chk("bp_done", a_done, 1);
        tick();

        // start and cfg_shift changes mid-layer are ignored
        r0 = rd_cnt;
        d0 = done_cnt;
        a_cfg_shift = 5'd0;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        tick();
        tick();
        a_start = 1'b1;
        a_cfg_shift = 5'd3;
        tick();
        tick();
        chk("restart_shift", a_dp_shift, 0);
        chk("restart_busy", a_busy, 1);
        a_start = 1'b0;
        n = 0;
        while (!a_done && n < 100) begin tick(); n++; end
        chk("restart_reads", rd_cnt - r0, 8);
        chk("restart_done_once", done_cnt - d0, 1);
        chk("restart_last_data", a_out_data, 16'h1464);
        chk("restart_shift_end", a_dp_shift, 0);
        tick();

        // Reset in the first drain cycle of group 0
        a_cfg_shift = 5'd2;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        repeat (4) tick();
        chk("pre_rst_shift", a_dp_shift, 2);
        rst = 1'b1;
        tick();
        chk("mid_rst_ctl",  {a_busy, a_done, a_in_rd_en, a_w_rd_en, a_dp_first, a_out_valid}, 64'd0);
        chk("mid_rst_addr", {a_in_addr, a_w_addr}, 64'd0);
        chk("mid_rst_dp",   {a_dp_pixel, a_dp_w, a_dp_shift}, 64'd0);
        chk("mid_rst_out",  {a_out_data, a_out_group}, 64'd0);
        rst = 1'b0;
        d0 = done_cnt;
        repeat (3) tick();
        chk("rst_no_done", done_cnt - d0, 0);
        chk("rst_idle", a_busy, 0);

        // Clean layer after reset, shift 2
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        n = 1;
        while (!a_out_valid && n < 100) begin tick(); n++; end
        chk("post_rst_lat", n, 7);
        chk("post_rst_g0", {a_out_data, a_out_group}, {16'h1919, 1'b0});
        n = 0;
        do begin tick(); n++; end while (!a_out_valid && n < 100);
        chk("post_rst_g1", {a_out_data, a_out_group}, {16'h0519, 1'b1});
        d0 = done_cnt;
        n = 0;
        while (!a_done && n < 100) begin tick(); n++; end
        chk("post_rst_done", done_cnt - d0, 1);
        chk("post_rst_shift", a_dp_shift, 2);
        tick();

        // N_IN = 1 configuration
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        n = 1;
        while (!b_out_valid && n < 100) begin tick(); n++; end
        chk("b_lat", n, 4);
        chk("b_g0", {b_out_data, b_out_group}, {16'h0707, 1'b0});
        n = 0;
        do begin tick(); n++; end while (!b_out_valid && n < 100);
        chk("b_lat_group", n, 4);
        chk("b_g1", {b_out_data, b_out_group}, {16'h07F9, 1'b1});
        tick();
        chk("b_done", {b_done, b_busy}, 2'b11);
        chk("b_reads", b_rd_cnt, 2);
        tick();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
